// File: rtl/ins_encoder_if.sv
// Host-to-encoder instruction fields plus the instruction memory write port.
// No storage; pure signal bundle, latency 0.
// Backpressure: host holds in_valid and fields until in_ready is seen high.
interface ins_encoder_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Host / boot loader side.
  modport master (
    output in_valid, op_sel, rs, rt, rd, imm, target, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Encoder side.
  modport slave (
    input  in_valid, op_sel, rs, rt, rd, imm, target, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ins_encoder.sv
// Packs mnemonic + fields into 32-bit instructions and writes them to imem at sequential addresses.
// Latency: accept at N -> mem_we at N+1, done (for in_last) at N+2.
// Backpressure: in_ready low in WRITE/DONE/FULL and while reset/start; optional INS_ENCODER_PSEUDO_NOT_EN maps not to nor rd,rs,rs.
module ins_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  ins_encoder_if.slave bus,
  output logic         done,
  output logic         err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE, FULL} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  count;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              last_q;
  logic              legal_q;
  logic              kill;
  logic              accept;
  logic              at_limit;
  logic [ADDR_W-1:0] wr_addr;

  // reset and start both abort whatever is in flight this cycle
  assign kill     = reset | start;
  assign accept   = bus.in_valid & bus.in_ready;
  assign at_limit = (count == CNT_W'(DEPTH));
  assign wr_addr  = BASE_ADDR + (ADDR_W'(count) << 2);

  // Combinational encoder: build the instruction word and flag unknown mnemonics
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (bus.op_sel)
      4'd0:  enc_word = {6'b100000, bus.rs, bus.rt, bus.rd, 11'd0};   // and
      4'd1:  enc_word = {6'b100011, bus.rs, bus.rt, bus.imm};         // lw
      4'd2:  enc_word = {6'b101011, bus.rs, bus.rt, bus.imm};         // sw
      4'd3:  enc_word = {6'b001000, bus.rs, 21'd0};                   // jr
      4'd4:  enc_word = {6'b000011, bus.target};                      // jal
      4'd5:  enc_word = {6'b100110, bus.rs, bus.rt, bus.rd, 11'd0};   // nor
      4'd6:  enc_word = {6'b001110, bus.rs, bus.rt, bus.imm};         // nori
`ifdef INS_ENCODER_PSEUDO_NOT_EN
      4'd7:  enc_word = {6'b100110, bus.rs, bus.rs, bus.rd, 11'd0};   // not as nor rd,rs,rs
`else
      4'd7:  enc_word = {6'b000100, bus.rs, 5'd0, bus.rd, 11'd0};     // native not, rt forced 0
`endif
      4'd8:  enc_word = {6'b010000, bus.rs, bus.rt, bus.imm};         // bleu
      4'd9:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 11'd0};   // rolv
      4'd10: enc_word = {6'b000010, bus.rs, bus.rt, bus.rd, 11'd0};   // rorv
      default: enc_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/strobe outputs; a kill cycle suppresses every strobe
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    done         = 1'b0;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready = 1'b1;
          if (bus.in_valid) begin
            if (at_limit) begin
              state_nxt = FULL;
            end else if (enc_legal) begin
              state_nxt = WRITE;
            end
          end
        end
        WRITE: begin
          bus.mem_we = legal_q;
          state_nxt  = last_q ? DONE : IDLE;
        end
        DONE: begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
        FULL: begin
          state_nxt = FULL;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: capture word/address on accept, track word count and the sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      err           <= 1'b0;
      last_q        <= 1'b0;
      legal_q       <= 1'b0;
      bus.mem_addr  <= BASE_ADDR;
      bus.mem_wdata <= '0;
    end else if (start) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (accept) begin
        legal_q <= enc_legal & ~at_limit;
        if (at_limit || !enc_legal) begin
          err <= 1'b1;
        end else begin
          // mem_addr/mem_wdata only move when a write is about to be issued
          bus.mem_addr  <= wr_addr;
          bus.mem_wdata <= enc_word;
          last_q        <= bus.in_last;
        end
      end
      if (state == WRITE) begin
        count <= count + CNT_W'(1);
      end else if (state == DONE) begin
        count <= '0;
      end
    end
  end

endmodule
